// File: rtl/cu_fsm.sv
// Multicycle control unit: sequences fetch, execute and write-back for each
// instruction and inserts a single INTR cycle at instruction boundaries.
//
// state | meaning
// INIT  | after reset: clear PC, force pcSource to 0
// FETCH | read instruction memory
// EXEC  | decode opcode, issue enables; loads go on to WB
// WB    | load data written to register file, PC advances
// INTR  | vector to mtvec, save mepc
module cu_fsm (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       intr,
   input  logic       mie,
   output logic       PCWrite,
   output logic       regWrite,
   output logic       memWE2,
   output logic       memRDEN1,
   output logic       memRDEN2,
   output logic       rst_out,
   output logic       csr_WE,
   output logic       int_taken,
   output logic       mret_exec
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      WB    = 3'd3,
      INTR  = 3'd4
   } state_t;

   state_t state_q, state_d;
   logic   intr_pend_q, intr_pend_d;
   logic   take_intr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= INIT;
         intr_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         intr_pend_q <= intr_pend_d;
      end
   end

   // Leaving INTR clears the pending flag, but a request still present on that edge re-arms it.
   assign intr_pend_d = intr | (intr_pend_q & (state_q != INTR));
   assign take_intr   = intr_pend_q & mie;

   always_comb begin
      state_d   = state_q;
      PCWrite   = 1'b0;
      regWrite  = 1'b0;
      memWE2    = 1'b0;
      memRDEN1  = 1'b0;
      memRDEN2  = 1'b0;
      rst_out   = 1'b0;
      csr_WE    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
      case (state_q)
         INIT: begin
            rst_out = 1'b1;
            state_d = FETCH;
         end
         FETCH: begin
            memRDEN1 = 1'b1;
            state_d  = EXEC;
         end
         EXEC: begin
            state_d = take_intr ? INTR : FETCH;
            PCWrite = 1'b1;
            case (opcode)
               OPC_LOAD: begin
                  PCWrite  = 1'b0;
                  memRDEN2 = 1'b1;
                  state_d  = WB;
               end
               OPC_STORE:  memWE2 = 1'b1;
               OPC_BRANCH: ;
               OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM, OPC_OP:
                  regWrite = 1'b1;
               OPC_SYSTEM: begin
                  if (func3 == 3'b000) begin
                     mret_exec = 1'b1;
                  end else begin
                     csr_WE   = 1'b1;
                     regWrite = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         WB: begin
            regWrite = 1'b1;
            PCWrite  = 1'b1;
            state_d  = take_intr ? INTR : FETCH;
         end
         INTR: begin
            int_taken = 1'b1;
            PCWrite   = 1'b1;
            state_d   = FETCH;
         end
         default: state_d = INIT;
      endcase
   end

endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm: per-cycle stimulus and expected output
// vectors are queued, then replayed and compared one cycle at a time.
module tb_cu_fsm;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic [2:0] func3 = 3'd0;
   logic       intr = 1'b0;
   logic       mie = 1'b0;
   logic       PCWrite, regWrite, memWE2, memRDEN1, memRDEN2;
   logic       rst_out, csr_WE, int_taken, mret_exec;

   int checks = 0;
   int errors = 0;

   cu_fsm dut (
      .CLK(CLK), .RST(RST), .opcode(opcode), .func3(func3), .intr(intr), .mie(mie),
      .PCWrite(PCWrite), .regWrite(regWrite), .memWE2(memWE2), .memRDEN1(memRDEN1),
      .memRDEN2(memRDEN2), .rst_out(rst_out), .csr_WE(csr_WE), .int_taken(int_taken),
      .mret_exec(mret_exec)
   );

   always #5 CLK = ~CLK;

   // {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, rst_out, csr_WE, int_taken, mret_exec}
   logic [8:0] outs;
   assign outs = {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, rst_out, csr_WE, int_taken, mret_exec};

   localparam logic [8:0] V_INIT  = 9'b000001000;
   localparam logic [8:0] V_FETCH = 9'b000100000;
   localparam logic [8:0] V_RW    = 9'b110000000;
   localparam logic [8:0] V_LD    = 9'b000010000;
   localparam logic [8:0] V_ST    = 9'b101000000;
   localparam logic [8:0] V_PC    = 9'b100000000;
   localparam logic [8:0] V_CSR   = 9'b110000100;
   localparam logic [8:0] V_MRET  = 9'b100000001;
   localparam logic [8:0] V_INTR  = 9'b100000010;

   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;

   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic [2:0] f3;
      logic       irq;
      logic       en;
      logic [8:0] exp;
      logic       chk_pend;
      logic       exp_pend;
   } stim_t;

   stim_t sb[$];

   task automatic push(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic irq, input logic en, input logic [8:0] e);
      stim_t s;
      s.rst = r; s.op = op; s.f3 = f3; s.irq = irq; s.en = en; s.exp = e;
      s.chk_pend = 1'b0; s.exp_pend = 1'b0;
      sb.push_back(s);
   endtask

   task automatic expect_pend(input logic p);
      sb[sb.size()-1].chk_pend = 1'b1;
      sb[sb.size()-1].exp_pend = p;
   endtask

   task automatic apply(input stim_t s);
      RST = s.rst; opcode = s.op; func3 = s.f3; intr = s.irq; mie = s.en;
   endtask

   task automatic test_reset;
      stim_t s;
      int n = 0;
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      push(1'b1, OP_R, 3'd0, 1'b1, 1'b1, V_INIT);
      push(1'b0, OP_R, 3'd0, 1'b0, 1'b1, V_INIT);
      expect_pend(1'b0);
      while (sb.size() != 0) begin
         s = sb.pop_front();
         apply(s);
         #1;
         checks++;
         if (outs !== s.exp) begin
            errors++;
            $display("FAIL reset step %0d: outputs %b, expected %b", n, outs, s.exp);
         end
         if (s.chk_pend) begin
            checks++;
            if (dut.intr_pend_q !== s.exp_pend) begin
               errors++;
               $display("FAIL reset_pend step %0d: intr_pend %b, expected %b", n, dut.intr_pend_q, s.exp_pend);
            end
         end
         @(negedge CLK);
         n++;
      end
   endtask

   task automatic test_exec;
      logic [6:0] ops[12];
      logic [2:0] f3s[12];
      logic [8:0] exps[12];
      stim_t s;
      int n = 0;
      ops  = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
               7'b1100011, 7'b0100011, 7'b0001111, 7'b1110011, 7'b1110011, 7'b1110011};
      f3s  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
      exps = '{V_RW, V_RW, V_RW, V_RW, V_RW, V_RW, V_PC, V_ST, V_PC, V_CSR, V_CSR, V_MRET};
      for (int i = 0; i < 12; i++) begin
         push(1'b0, ops[i], f3s[i], 1'b0, 1'b1, V_FETCH);
         push(1'b0, ops[i], f3s[i], 1'b0, 1'b1, exps[i]);
      end
      while (sb.size() != 0) begin
         s = sb.pop_front();
         apply(s);
         #1;
         checks++;
         if (outs !== s.exp) begin
            errors++;
            $display("FAIL exec step %0d (opcode %b func3 %b): outputs %b, expected %b",
                     n, s.op, s.f3, outs, s.exp);
         end
         @(negedge CLK);
         n++;
      end
   endtask

   task automatic test_load;
      stim_t s;
      int n = 0;
      for (int i = 0; i < 2; i++) begin
         push(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, V_FETCH);
         push(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, V_LD);
         push(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, V_RW);
      end
      push(1'b0, OP_R, 3'd0, 1'b0, 1'b1, V_FETCH);
      push(1'b0, OP_R, 3'd0, 1'b0, 1'b1, V_RW);
      while (sb.size() != 0) begin
         s = sb.pop_front();
         apply(s);
         #1;
         checks++;
         if (outs !== s.exp) begin
            errors++;
            $display("FAIL load step %0d: outputs %b, expected %b", n, outs, s.exp);
         end
         @(negedge CLK);
         n++;
      end
   endtask

   task automatic test_intr;
      stim_t s;
      int n = 0;
      // store with interrupt pulse in FETCH
      push(1'b0, OP_ST, 3'd2, 1'b1, 1'b1, V_FETCH);
      push(1'b0, OP_ST, 3'd2, 1'b0, 1'b1, V_ST);
      push(1'b0, OP_ST, 3'd2, 1'b0, 1'b1, V_INTR);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_FETCH);
      expect_pend(1'b0);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_RW);
      // load: not taken in its EXEC, taken after WB
      push(1'b0, OP_LD, 3'd2, 1'b1, 1'b1, V_FETCH);
      push(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, V_LD);
      push(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, V_RW);
      push(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, V_INTR);
      // intr high on the edge leaving INTR re-arms the pending flag
      push(1'b0, OP_R,  3'd0, 1'b1, 1'b1, V_FETCH);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_RW);
      push(1'b0, OP_R,  3'd0, 1'b1, 1'b1, V_INTR);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_FETCH);
      expect_pend(1'b1);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_RW);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_INTR);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_FETCH);
      expect_pend(1'b0);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_RW);
      while (sb.size() != 0) begin
         s = sb.pop_front();
         apply(s);
         #1;
         checks++;
         if (outs !== s.exp) begin
            errors++;
            $display("FAIL intr step %0d: outputs %b, expected %b", n, outs, s.exp);
         end
         if (s.chk_pend) begin
            checks++;
            if (dut.intr_pend_q !== s.exp_pend) begin
               errors++;
               $display("FAIL intr_pend step %0d: intr_pend %b, expected %b", n, dut.intr_pend_q, s.exp_pend);
            end
         end
         @(negedge CLK);
         n++;
      end
   endtask

   task automatic test_mie_hold;
      stim_t s;
      int n = 0;
      int intr_seen = 0;
      for (int i = 0; i < 3; i++) begin
         push(1'b0, OP_R, 3'd0, (i == 0), 1'b0, V_FETCH);
         if (i != 0) expect_pend(1'b1);
         push(1'b0, OP_R, 3'd0, 1'b0, 1'b0, V_RW);
      end
      push(1'b0, OP_R, 3'd0, 1'b0, 1'b1, V_FETCH);
      expect_pend(1'b1);
      push(1'b0, OP_R, 3'd0, 1'b0, 1'b1, V_RW);
      push(1'b0, OP_R, 3'd0, 1'b0, 1'b1, V_INTR);
      for (int i = 0; i < 2; i++) begin
         push(1'b0, OP_R, 3'd0, 1'b0, 1'b1, V_FETCH);
         if (i == 0) expect_pend(1'b0);
         push(1'b0, OP_R, 3'd0, 1'b0, 1'b1, V_RW);
      end
      while (sb.size() != 0) begin
         s = sb.pop_front();
         apply(s);
         #1;
         if (int_taken === 1'b1) intr_seen++;
         checks++;
         if (outs !== s.exp) begin
            errors++;
            $display("FAIL mie_hold step %0d: outputs %b, expected %b", n, outs, s.exp);
         end
         if (s.chk_pend) begin
            checks++;
            if (dut.intr_pend_q !== s.exp_pend) begin
               errors++;
               $display("FAIL mie_pend step %0d: intr_pend %b, expected %b", n, dut.intr_pend_q, s.exp_pend);
            end
         end
         @(negedge CLK);
         n++;
      end
      checks++;
      if (intr_seen != 1) begin
         errors++;
         $display("FAIL mie_intr_count: INTR visits %0d, expected 1", intr_seen);
      end
   endtask

   task automatic test_reset_mid;
      stim_t s;
      int n = 0;
      push(1'b0, OP_LD, 3'd2, 1'b1, 1'b1, V_FETCH);
      push(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, V_LD);
      push(1'b1, OP_LD, 3'd2, 1'b1, 1'b1, V_RW);
      push(1'b0, OP_LD, 3'd2, 1'b0, 1'b1, V_INIT);
      expect_pend(1'b0);
      push(1'b0, OP_R,  3'd0, 1'b1, 1'b1, V_FETCH);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_RW);
      push(1'b1, OP_R,  3'd0, 1'b1, 1'b1, V_INTR);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_INIT);
      expect_pend(1'b0);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_FETCH);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_RW);
      push(1'b0, OP_R,  3'd0, 1'b0, 1'b1, V_FETCH);
      while (sb.size() != 0) begin
         s = sb.pop_front();
         apply(s);
         #1;
         checks++;
         if (outs !== s.exp) begin
            errors++;
            $display("FAIL reset_mid step %0d: outputs %b, expected %b", n, outs, s.exp);
         end
         if (s.chk_pend) begin
            checks++;
            if (dut.intr_pend_q !== s.exp_pend) begin
               errors++;
               $display("FAIL reset_mid_pend step %0d: intr_pend %b, expected %b", n, dut.intr_pend_q, s.exp_pend);
            end
         end
         @(negedge CLK);
         n++;
      end
   endtask

   initial begin
      test_reset();
      test_exec();
      test_load();
      test_intr();
      test_mie_hold();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
